lfsr_gen: RTL and testbench

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen.sv | 114 +++++++++++
 tb/tb_lfsr_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci-style LFSR with a configurable tap mask and multi-bit
// stepping.
//
// Handshake: there is no backpressure. A request is taken on every rising
// edge of clk_i. load_i has priority over en_i. valid_o is high for exactly
// the one cycle that follows an edge that loaded or advanced the state.
//
// Optional feature: define LFSR_GEN_LOCKUP_RECOVER_EN to make an advance
// from the all-zero state reload SEED. Without it the all-zero state is
// sticky until reset or a load of a nonzero seed.
//
// Parameter legality: WIDTH 4..32, STEP 1..WIDTH, SEED nonzero.

module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] out_o,
  output logic             valid_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  // Registered state. All outputs come straight from these flops, so there
  // is no combinational path from any input to any output.
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] start_q;
  logic             valid_q;
  logic             wrap_q;
  logic             lockup_q;

  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] start_d;
  logic             valid_d;
  logic             wrap_d;
  logic [WIDTH-1:0] stepped;
  logic             locked;

  // STEP chained single-bit shifts: feedback is the parity of the tapped
  // bits and enters at bit 0 while the register shifts towards the MSB.
  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < STEP; i++) begin
      v = {v[WIDTH-2:0], ^(v & TAPS)};
    end
    return v;
  endfunction

  // Next-state selection: load beats advance, advance beats hold.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    stepped = lfsr_advance(state_q);
    locked  = (state_q == '0);
    if (load_i) begin
      // A load defines a new start value and never counts as a wrap.
      state_d = seed_i;
      start_d = seed_i;
      valid_d = 1'b1;
    end else if (en_i) begin
      valid_d = 1'b1;
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
      if (locked) begin
        // Escape the all-zero trap by restarting the sequence from SEED.
        state_d = SEED;
        start_d = SEED;
      end else begin
        state_d = stepped;
        wrap_d  = (stepped == start_q);
      end
`else
      // The all-zero state maps onto itself; it is not a real sequence, so
      // it never reports a wrap.
      if (!locked) begin
        state_d = stepped;
        wrap_d  = (stepped == start_q);
      end
`endif
    end
  end

  // State register with synchronous reset overriding load and advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SEED;
      start_q  <= SEED;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= (state_d == '0);
    end
  end

  assign out_o    = state_q;
  assign valid_o  = valid_q;
  assign wrap_o   = wrap_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen, default 8-bit configuration plus
// a STEP=2 instance sharing the same inputs.

module tb_lfsr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] seed;

  logic [7:0] out1;
  logic       valid1;
  logic       wrap1;
  logic       lock1;
  logic [7:0] out2;
  logic       valid2;
  logic       wrap2;
  logic       lock2;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(1)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_i(seed),
    .out_o(out1), .valid_o(valid1), .wrap_o(wrap1), .lockup_o(lock1)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_i(seed),
    .out_o(out2), .valid_o(valid2), .wrap_o(wrap2), .lockup_o(lock2)
  );

  // Reference single shift written from the tap definition.
  function automatic logic [7:0] ref_shift(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  // driver tasks: inputs change on the falling edge, outputs are sampled
  // on the falling edge after the rising edge that acted on them
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; seed = 8'h55;
    tick();
    rst = 1'b0; en = 1'b0; load = 1'b0;
    checks++; if (out1 !== 8'h01) begin errors++; $display("FAIL reset_out: got %h expected 01", out1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid1); end
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap1); end
    checks++; if (lock1 !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b expected 0", lock1); end
    checks++; if (out2 !== 8'h01) begin errors++; $display("FAIL reset_out_step2: got %h expected 01", out2); end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    exp_q = '{8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (out1 !== e) begin errors++; $display("FAIL seq_out[%0d]: got %h expected %h", i, out1, e); end
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, valid1); end
    end
    en = 1'b0;
  endtask

  task automatic test_hold();
    logic [7:0] held;
    held = out1;
    en = 1'b0; load = 1'b0;
    tick();
    checks++; if (out1 !== held) begin errors++; $display("FAIL hold_out: got %h expected %h", out1, held); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b expected 0", valid1); end
  endtask

  task automatic test_wrap();
    logic [7:0] m;
    int wraps;
    do_reset();
    m = 8'h01; wraps = 0;
    en = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      m = ref_shift(m);
      if (wrap1 === 1'b1) wraps++;
      checks++; if (out1 !== m) begin errors++; $display("FAIL wrap_seq_out[%0d]: got %h expected %h", i, out1, m); end
      checks++; if (wrap1 !== (i == 255)) begin errors++; $display("FAIL wrap_flag[%0d]: got %b expected %b", i, wrap1, (i == 255)); end
    end
    checks++; if (out1 !== 8'h01) begin errors++; $display("FAIL wrap_end_out: got %h expected 01", out1); end
    checks++; if (wraps != 1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", wraps); end
    tick();
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL wrap_drop: got %b expected 0", wrap1); end
    checks++; if (out1 !== 8'h02) begin errors++; $display("FAIL wrap_after_out: got %h expected 02", out1); end
    en = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] m;
    do_reset();
    load = 1'b1; en = 1'b1; seed = 8'hA5;
    tick();
    load = 1'b0;
    checks++; if (out1 !== 8'hA5) begin errors++; $display("FAIL load_out: got %h expected a5", out1); end
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", valid1); end
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL load_wrap: got %b expected 0", wrap1); end
    m = 8'hA5;
    for (int i = 1; i <= 255; i++) begin
      tick();
      m = ref_shift(m);
      checks++; if (out1 !== m) begin errors++; $display("FAIL load_seq_out[%0d]: got %h expected %h", i, out1, m); end
      checks++; if (wrap1 !== (i == 255)) begin errors++; $display("FAIL load_wrap_flag[%0d]: got %b expected %b", i, wrap1, (i == 255)); end
    end
    checks++; if (out1 !== 8'hA5) begin errors++; $display("FAIL load_wrap_out: got %h expected a5", out1); end
    en = 1'b0;
  endtask

  task automatic test_lockup();
    do_reset();
    load = 1'b1; seed = 8'h00;
    tick();
    load = 1'b0;
    checks++; if (out1 !== 8'h00) begin errors++; $display("FAIL lock_load_out: got %h expected 00", out1); end
    checks++; if (lock1 !== 1'b1) begin errors++; $display("FAIL lock_flag: got %b expected 1", lock1); end
    en = 1'b1;
    tick();
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
    checks++; if (out1 !== 8'h01) begin errors++; $display("FAIL lock_recover_out: got %h expected 01", out1); end
    checks++; if (lock1 !== 1'b0) begin errors++; $display("FAIL lock_recover_flag: got %b expected 0", lock1); end
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL lock_recover_valid: got %b expected 1", valid1); end
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL lock_recover_wrap: got %b expected 0", wrap1); end
    tick();
    checks++; if (out1 !== 8'h02) begin errors++; $display("FAIL lock_recover_next: got %h expected 02", out1); end
`else
    checks++; if (out1 !== 8'h00) begin errors++; $display("FAIL lock_stuck_out: got %h expected 00", out1); end
    checks++; if (lock1 !== 1'b1) begin errors++; $display("FAIL lock_stuck_flag: got %b expected 1", lock1); end
    tick();
    checks++; if (out1 !== 8'h00) begin errors++; $display("FAIL lock_stuck_out2: got %h expected 00", out1); end
    checks++; if (lock1 !== 1'b1) begin errors++; $display("FAIL lock_stuck_flag2: got %b expected 1", lock1); end
`endif
    en = 1'b0;
    load = 1'b1; seed = 8'h03;
    tick();
    load = 1'b0;
    checks++; if (lock1 !== 1'b0) begin errors++; $display("FAIL lock_clear_flag: got %b expected 0", lock1); end
    checks++; if (out1 !== 8'h03) begin errors++; $display("FAIL lock_clear_out: got %h expected 03", out1); end
  endtask

  task automatic test_step2();
    int wraps;
    do_reset();
    en = 1'b1;
    tick();
    checks++; if (out2 !== 8'h04) begin errors++; $display("FAIL step2_first: got %h expected 04", out2); end
    checks++; if (out1 !== 8'h02) begin errors++; $display("FAIL step1_first: got %h expected 02", out1); end
    checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL step2_wrap_first: got %b expected 0", wrap2); end
    wraps = 0;
    for (int i = 2; i <= 255; i++) begin
      tick();
      if (wrap2 === 1'b1) wraps++;
      checks++; if (wrap2 !== (i == 255)) begin errors++; $display("FAIL step2_wrap[%0d]: got %b expected %b", i, wrap2, (i == 255)); end
    end
    checks++; if (out2 !== 8'h01) begin errors++; $display("FAIL step2_wrap_out: got %h expected 01", out2); end
    checks++; if (wraps != 1) begin errors++; $display("FAIL step2_wrap_count: got %0d expected 1", wraps); end
    en = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    en = 1'b1;
    repeat (4) tick();
    checks++; if (out1 !== 8'h11) begin errors++; $display("FAIL mid_pre_out: got %h expected 11", out1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out1 !== 8'h01) begin errors++; $display("FAIL mid_rst_out: got %h expected 01", out1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", valid1); end
    checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL mid_rst_wrap: got %b expected 0", wrap1); end
    tick();
    checks++; if (out1 !== 8'h02) begin errors++; $display("FAIL mid_after_out: got %h expected 02", out1); end
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL mid_after_valid: got %b expected 1", valid1); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 8'h00;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_hold();
    test_wrap();
    test_load();
    test_lockup();
    test_step2();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
